// File: rtl/fetch_pkg.sv
// Shared widths and defaults for the instruction fetch block.
package fetch_pkg;
  localparam int XLEN        = 64;
  localparam int ILEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;
endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready output register holding one fetched instruction and its PC.
module fetch_out_reg
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic            ready_i,
  input  logic [ILEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o
);
  logic            valid_q, valid_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;

  // Flush beats load; an accepted word with no refill drains.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
endmodule

// File: rtl/instruction_fetch.sv
// Single-entry instruction fetch: PC register, redirect/fault handling, output register.
// Optional FETCH_BOUND_CHECK_EN faults instead of fetching past IMEM_BYTES.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              IMEM_BYTES = 88
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] inst_address,
  input  logic [ILEN-1:0] instruction,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            fault
);
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;
  logic            fire_ok, fire, bound_fault;

  assign fire_ok = !fault_q && !redirect_valid && (!out_valid || out_ready);

`ifdef FETCH_BOUND_CHECK_EN
  logic [XLEN:0] pc_end;
  logic          oob;
  // One extra bit so the top word of the address space still counts as past the end.
  assign pc_end      = {1'b0, pc_q} + (XLEN+1)'(INSTR_BYTES);
  assign oob         = pc_end > (XLEN+1)'(IMEM_BYTES);
  assign fire        = fire_ok && !oob;
  assign bound_fault = fire_ok && oob;
`else
  assign fire        = fire_ok;
  assign bound_fault = 1'b0;
`endif

  always_comb begin
    pc_d    = pc_q;
    fault_d = fault_q | bound_fault;
    if (redirect_valid) begin
      if (redirect_pc[1:0] != 2'b00) fault_d = 1'b1;
      else                           pc_d    = redirect_pc;
    end else if (fire) begin
      pc_d = pc_q + XLEN'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  fetch_out_reg u_out (
    .clk     (clk),
    .rst     (reset),
    .load_i  (fire),
    .flush_i (redirect_valid),
    .ready_i (out_ready),
    .instr_i (instruction),
    .pc_i    (pc_q),
    .valid_o (out_valid),
    .instr_o (out_instr),
    .pc_o    (out_pc)
  );

  assign inst_address = pc_q;
  assign fault        = fault_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small combinational instruction memory.
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] inst_address;
  logic [31:0] instruction;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        fault;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [0:21];

  always #5 clk = ~clk;

  // Out-of-range addresses read as zero.
  always_comb begin
    instruction = 32'h0;
    if (inst_address < 64'd88) instruction = mem[inst_address[6:2]];
  end

  instruction_fetch #(.RESET_PC(64'h0), .IMEM_BYTES(88)) dut (
    .clk            (clk),
    .reset          (reset),
    .inst_address   (inst_address),
    .instruction    (instruction),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic redirect(input logic [63:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc = tgt;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 22; i++) mem[i] = 32'h0000_0013;
    mem[0]  = 32'h0000_0913;
    mem[1]  = 32'h0000_0433;
    mem[2]  = 32'h04b4_0863;
    mem[14] = 32'hfe00_04e3;
    mem[21] = 32'hfa00_0ae3;

    // Asynchronous reset, observed before any clock edge.
    #2 reset = 1'b1;
    #1;
    chk("rst_addr_async", inst_address, 64'h0);
    chk("rst_valid_async", {63'b0, out_valid}, 64'h0);
    chk("rst_fault_async", {63'b0, fault}, 64'h0);
    step();
    chk("rst_addr_held", inst_address, 64'h0);
    chk("rst_valid_held", {63'b0, out_valid}, 64'h0);
    chk("rst_opc", out_pc, 64'h0);
    reset = 1'b0;

    // Streaming fetch.
    step();
    chk("f0_pc", out_pc, 64'h0);
    chk("f0_instr", {32'h0, out_instr}, 64'h0000_0913);
    chk("f0_valid", {63'b0, out_valid}, 64'h1);
    step();
    chk("f1_pc", out_pc, 64'h4);
    chk("f1_instr", {32'h0, out_instr}, 64'h0000_0433);
    step();
    chk("f2_pc", out_pc, 64'h8);
    chk("f2_instr", {32'h0, out_instr}, 64'h04b4_0863);

    // Stall after the first fetch.
    do_reset();
    step();
    chk("st0_pc", out_pc, 64'h0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_opc", out_pc, 64'h0);
      chk("st_addr", inst_address, 64'h4);
      chk("st_valid", {63'b0, out_valid}, 64'h1);
    end
    out_ready = 1'b1;
    step();
    chk("st_rel_pc", out_pc, 64'h4);
    chk("st_rel_instr", {32'h0, out_instr}, 64'h0000_0433);

    // Redirect while stalled drops the held output.
    out_ready = 1'b0;
    redirect(64'h38);
    chk("rd_valid", {63'b0, out_valid}, 64'h0);
    chk("rd_addr", inst_address, 64'h38);
    out_ready = 1'b1;
    step();
    chk("rd_pc", out_pc, 64'h38);
    chk("rd_instr", {32'h0, out_instr}, 64'hfe00_04e3);

    // Redirect and out_ready together: redirect wins.
    redirect(64'h0);
    chk("rdr_valid", {63'b0, out_valid}, 64'h0);
    chk("rdr_addr", inst_address, 64'h0);
    step();
    chk("rdr_pc", out_pc, 64'h0);
    chk("rdr_instr", {32'h0, out_instr}, 64'h0000_0913);

    // Misaligned redirect: sticky fault, PC held.
    redirect(64'h3A);
    chk("mis_fault", {63'b0, fault}, 64'h1);
    chk("mis_valid", {63'b0, out_valid}, 64'h0);
    chk("mis_addr", inst_address, 64'h4);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mis_fault_hold", {63'b0, fault}, 64'h1);
      chk("mis_nofetch", {63'b0, out_valid}, 64'h0);
      chk("mis_addr_hold", inst_address, 64'h4);
    end

    // Reset while faulted clears everything; first fetch on first edge after release.
    reset = 1'b1;
    #1;
    chk("rf_fault_async", {63'b0, fault}, 64'h0);
    step();
    reset = 1'b0;
    step();
    chk("rf_pc", out_pc, 64'h0);
    chk("rf_valid", {63'b0, out_valid}, 64'h1);

    // Bound check at the end of memory.
    do_reset();
    redirect(64'h54);
    step();
    chk("bnd_pc", out_pc, 64'h54);
    chk("bnd_instr", {32'h0, out_instr}, 64'hfa00_0ae3);
    chk("bnd_addr", inst_address, 64'h58);
    step();
`ifdef FETCH_BOUND_CHECK_EN
    chk("bnd_fault", {63'b0, fault}, 64'h1);
    chk("bnd_valid", {63'b0, out_valid}, 64'h0);
    chk("bnd_addr_hold", inst_address, 64'h58);
`else
    chk("bnd_fault", {63'b0, fault}, 64'h0);
    chk("bnd_next_pc", out_pc, 64'h58);
    chk("bnd_addr_next", inst_address, 64'h5C);
`endif

    // Wrap at the top of the address space.
    do_reset();
    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    chk("wr_addr", inst_address, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
`ifdef FETCH_BOUND_CHECK_EN
    chk("wr_fault", {63'b0, fault}, 64'h1);
    chk("wr_addr_hold", inst_address, 64'hFFFF_FFFF_FFFF_FFFC);
`else
    chk("wr_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wr_addr_wrap", inst_address, 64'h0);
    chk("wr_fault", {63'b0, fault}, 64'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0: PC value loaded on reset.
REQ-002 Parameter IMEM_BYTES, default 88: instruction memory size in bytes, used only by the bound check.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 inst_address  output  64  byte address driven to the instruction memory.
REQ-006 instruction  input  32  little-endian word returned combinationally by the memory for inst_address.
REQ-007 redirect_valid  input  1  branch/jump redirect request.
REQ-008 redirect_pc  input  64  redirect target byte address.
REQ-009 out_valid  output  1  out_instr/out_pc hold a fetched instruction.
REQ-010 out_ready  input  1  consumer accepts the output this cycle.
REQ-011 out_instr  output  32  fetched instruction word.
REQ-012 out_pc  output  64  byte address of out_instr.
REQ-013 fault  output  1  sticky fetch fault; fetching stops while set.

Function
REQ-014 The block SHALL hold a 64-bit PC register and drive inst_address directly from it, with no combinational path from any input.
REQ-015 A fetch SHALL fire in a cycle when all of the following hold: fault=0, redirect_valid=0, and (out_valid=0 or out_ready=1).
- On fire: out_instr<=instruction, out_pc<=PC, out_valid<=1, PC<=PC+4.
REQ-016 Latency: the word at address A SHALL appear on out_instr, with out_valid=1, on the edge after PC=A is presented.
REQ-017 If out_valid=1 and out_ready=0, then out_valid, out_instr, out_pc and PC SHALL all hold.
REQ-018 If out_valid=1, out_ready=1 and no fetch fires, out_valid SHALL clear on the next edge.
REQ-019 redirect_valid=1 SHALL take priority over fetch and hold:
- PC<=redirect_pc.
- out_valid<=0, discarding any unaccepted output.
- No fetch occurs that cycle.
REQ-020 A redirect with redirect_pc[1:0]!=0 SHALL:
- set fault;
- leave PC unchanged;
- clear out_valid.
REQ-021 fault SHALL remain set until reset, and no fetch SHALL fire while it is set.
REQ-022 PC+4 SHALL wrap modulo 2^64; the fetch at 64'hFFFF_FFFF_FFFF_FFFC yields next PC 0.
REQ-023 Simultaneous redirect_valid and out_ready: the redirect SHALL win; the current output counts as consumed, then is dropped.

Reset
REQ-024 On reset assertion, asynchronously:
- PC=RESET_PC.
- out_valid=0, out_instr=0, out_pc=0, fault=0.
REQ-025 Reset asserted mid-stall or mid-redirect SHALL discard all in-flight state; the first fetch SHALL fire on the first edge after deassertion.

Configuration
REQ-026 Macro FETCH_BOUND_CHECK_EN, when defined, SHALL set fault instead of firing whenever a fetch would otherwise fire with PC+4 > IMEM_BYTES.
REQ-027 Without FETCH_BOUND_CHECK_EN, no bound check SHALL exist, IMEM_BYTES SHALL be unused, and out-of-range fetches proceed normally.

Structure
REQ-028 Package fetch_pkg SHALL hold XLEN=64, ILEN=32, INSTR_BYTES=4 and the default RESET_PC.
REQ-029 The valid/ready output register SHALL be one sub-module, fetch_out_reg; PC logic and fault logic stay in the top module.

Verification (bench pairs the block with the instruction memory holding 0x00000913, 0x00000433, 0x04b40863 at byte addresses 0, 4, 8)
REQ-030 Reset pulse with out_ready=1 -> inst_address=0 and out_valid=0 during reset; after release, (out_pc, out_instr) = (0, 0x00000913), (4, 0x00000433), (8, 0x04b40863) on consecutive edges.
REQ-031 out_ready=0 for 3 cycles after the first fetch -> out_pc=0 and inst_address=4 held throughout; on release, 0x00000433 follows exactly one edge later.
REQ-032 redirect_valid=1 with redirect_pc=0x38 while out_valid=1 and out_ready=0 -> out_valid=0 on the next edge, then out_pc=0x38 with out_instr=0xfe0004e3.
REQ-033 redirect_pc=0x3A -> fault=1 and out_valid=0; fault stays 1 and no fetch fires until reset.
REQ-034 FETCH_BOUND_CHECK_EN defined, redirect_pc=0x54 -> 0xfa000ae3 fetched at 0x54, then fault=1 with PC=0x58; macro undefined -> fetch proceeds at 0x58 with fault=0.
REQ-035 Redirect to 0xFFFF_FFFF_FFFF_FFFC without FETCH_BOUND_CHECK_EN -> after that fetch, inst_address=0 and fault=0.
